genius_engine: RTL and testbench
================================

# genius_engine

Parametrised successor to the fixed three-button, 16-step game FSM. It generates a pseudo-random sequence on chip, one new element per round, and plays it back on `N_BTN` LEDs with programmable on/gap timing. It then checks the player's replay with timeout and edge detection, and reports round, best score and win/lose status. It sits between the debounced button inputs and the existing seven-segment and LED display logic.

## Interface
Parameters:
- `N_BTN`, default 4: number of buttons/LEDs, legal range 2..8. `IW = $clog2(N_BTN)`.
- `MAX_LEN`, default 16: sequence length needed to win, legal range 1..255. `RW = $clog2(MAX_LEN+1)`.
- `SHOW_TICKS`, default 4: cycles each element is lit during playback, minimum 1.
- `GAP_TICKS`, default 2: dark cycles after each element, minimum 1.
- `TIMEOUT_TICKS`, default 64: idle cycles allowed per expected press.
- `LFSR_SEED`, default 8'hA5: LFSR reset value. Must be non-zero.

Ports:
- `clock`, in, 1: the single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: its rising edge starts a new game from any state.
- `btn`, in, N_BTN: button levels, active high, already synchronised and debounced.
- `led`, out, N_BTN: one-hot playback or echo. Reset value 0.
- `round`, out, RW: current sequence length. Reset value 0.
- `best`, out, RW: highest count of completed rounds since reset. Reset value 0.
- `win`, out, 1: held high in WIN. Reset value 0.
- `lose`, out, 1: held high in LOSE. Reset value 0.
- `busy`, out, 1: high in every state except IDLE, WIN and LOSE. Reset value 0.

## Operation
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. It advances every cycle after reset and is never held.
- New element value: `v = lfsr[IW-1:0]`. If `v >= N_BTN`, use `v - N_BTN`.
- Sequence memory: `MAX_LEN` entries of IW bits each. It is written only in APPEND.
- Edge detection: `btn_q` registers `btn` every cycle. The press vector is `btn & ~btn_q`.
- A `start` rising edge, registered the same way, forces APPEND with `round` set to 0. It clears `win`/`lose` and overrides every transition below.
- IDLE: `led` = 0. Waits for `start`.
- APPEND:
  - Writes `mem[round]` with the new element and increments `round`.
  - Sets idx = 0 and tick = 0.
  - Goes to SHOW_ON.
- SHOW_ON: `led` = onehot(`mem[idx]`) for SHOW_TICKS cycles, then goes to SHOW_OFF.
- SHOW_OFF: `led` = 0 for GAP_TICKS cycles. Then:
  - If idx == `round`-1: set idx = 0, clear the timer, go to WAIT_IN.
  - Otherwise: increment idx and go to SHOW_ON.
- WAIT_IN: `led` = 0.
  - No press: the timer increments. When it reaches TIMEOUT_TICKS-1, go to LOSE.
  - Press vector equals onehot(`mem[idx]`): increment idx and go to RELEASE.
  - Any other non-zero press vector, including several simultaneous presses: go to LOSE.
- RELEASE: `led` = `btn` (echo). Waits for `btn` == 0. Then:
  - If idx < `round`: clear the timer and go to WAIT_IN.
  - Else if `round` == MAX_LEN: go to WIN.
  - Else: go to APPEND.
- WIN: `led` = all ones, `win` = 1.
- LOSE: `led` = 0, `lose` = 1.
- Completed rounds: `round` on entry to WIN, `round`-1 on entry to LOSE. On entry to WIN or LOSE, `best` is updated to completed rounds if that value is larger.
- Counter widths: tick and timer are sized with `$clog2` of their limits and saturate, never wrap. idx is RW bits.

## Timing
- All outputs are registered and change on the `clock` edge after the causing condition.
- Playback of a round of length L takes exactly L*(SHOW_TICKS+GAP_TICKS) cycles, plus 1 APPEND cycle.
- A press is seen in the cycle `btn` rises. The state changes on the next edge.
- A button held across the transition into WAIT_IN does not count as a press; only a new rising edge does.
- Timeout: exactly TIMEOUT_TICKS cycles in WAIT_IN with no press, then LOSE.
- `reset_n` low at any time forces IDLE and all reset values, including `best` and the LFSR. Memory contents need not be cleared.
- A `start` edge mid-show or mid-input restarts on the next edge. `best` is not updated by the aborted game.

## Structure
- Package `genius_pkg` holds:
  - the state enum: IDLE, APPEND, SHOW_ON, SHOW_OFF, WAIT_IN, RELEASE, WIN, LOSE;
  - the LFSR tap constant;
  - the `onehot` function.
- Sub-module `genius_lfsr` (parameter seed; ports `clock`, `reset_n`, `q[7:0]`).
- Seven-segment decoding of `round`/`best` stays outside this block.

## Test plan
- Reset: assert `reset_n` = 0 mid-SHOW_ON -> `led` = 0, `round` = 0, `best` = 0, `win`/`lose` = 0, `busy` = 0 immediately.
- Playback, default parameters: pulse `start` -> `busy` = 1, `round` = 1, one `led` bit high for exactly 4 cycles then 0 for 2 cycles, the bit matches the reference LFSR model.
- Correct replay for 3 rounds, driven from the model -> `round` = 3. Round 3 playback lasts 18 cycles. `led` echoes each held button.
- Errors:
  - Wrong button in round 2 -> `lose` = 1, `best` = 1.
  - Two buttons rising in the same cycle -> `lose` = 1.
- Timeout: no press in WAIT_IN -> `lose` rises exactly 64 cycles after entry.
- MAX_LEN = 4 perfect game -> `win` = 1, `led` = all ones, `best` = 4. A `start` edge then gives `win` = 0, `round` = 1, `best` = 4.

Source files
------------

// File: rtl/genius_pkg.sv
// genius_pkg: shared types and helpers for the sequence memory game engine.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package genius_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPEND,
        SHOW_ON,
        SHOW_OFF,
        WAIT_IN,
        RELEASE,
        WIN,
        LOSE
    } state_t;

    // Fibonacci taps for x^8 + x^6 + x^5 + x^4 + 1 on a left-shifting register
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // One-hot decode of a button index; callers truncate to their button count
    function automatic logic [7:0] onehot(input logic [2:0] v);
        logic [7:0] r;
        r    = 8'd0;
        r[v] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/genius_lfsr.sv
// genius_lfsr: free-running 8-bit Fibonacci LFSR feeding new game elements.
// Latency: new value every cycle after reset release, never held.
// Backpressure: none; consumers sample whatever value is current.
module genius_lfsr
    import genius_pkg::*;
#(
    parameter logic [7:0] seed = 8'hA5
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic [7:0] q
);

    // Shift left, feeding back the parity of the tapped stages
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= seed;
        end else begin
            q <= {q[6:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/genius_engine.sv
// genius_engine: sequence memory game - appends a random element per round, plays it back, checks the replay.
// Latency: all outputs registered from the next state; they follow the causing condition by one clock edge.
// Backpressure: none; buttons are sampled every cycle and playback never stalls.
module genius_engine
    import genius_pkg::*;
#(
    parameter int         N_BTN         = 4,
    parameter int         MAX_LEN       = 16,
    parameter int         SHOW_TICKS    = 4,
    parameter int         GAP_TICKS     = 2,
    parameter int         TIMEOUT_TICKS = 64,
    parameter logic [7:0] LFSR_SEED     = 8'hA5,
    localparam int        IW            = $clog2(N_BTN),
    localparam int        RW            = $clog2(MAX_LEN + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] led,
    output logic [RW-1:0]    round,
    output logic [RW-1:0]    best,
    output logic             win,
    output logic             lose,
    output logic             busy
);

    localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMAX = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int OW   = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [IW:0]   NB_W   = (IW + 1)'(N_BTN);
    localparam logic [IW-1:0] NB_I   = IW'(N_BTN);
    localparam logic [TW-1:0] SHOW_L = TW'(SHOW_TICKS - 1);
    localparam logic [TW-1:0] GAP_L  = TW'(GAP_TICKS - 1);
    localparam logic [OW-1:0] TO_L   = OW'(TIMEOUT_TICKS - 1);
    localparam logic [RW-1:0] MAX_R  = RW'(MAX_LEN);

    state_t           state, state_n;
    logic [RW-1:0]    round_n, best_n, idx, idx_n, done;
    logic [TW-1:0]    tick, tick_n;
    logic [OW-1:0]    timer, timer_n;
    logic [N_BTN-1:0] btn_q, press, led_n;
    logic             start_q, start_rise;
    logic             mem_we;
    logic [IW-1:0]    mem [MAX_LEN];
    logic [IW-1:0]    new_elem, show_elem;
    logic [7:0]       exp_oh;
    logic [7:0]       lfsr_q;

    genius_lfsr #(
        .seed (LFSR_SEED)
    ) u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .q       (lfsr_q)
    );

    assign press      = btn & ~btn_q;
    assign start_rise = start & ~start_q;

    // Fold the LFSR value into the legal button range
    always_comb begin
        new_elem = IW'(lfsr_q);
        if ({1'b0, new_elem} >= NB_W) begin
            new_elem = new_elem - NB_I;
        end
    end

    // Next-state, counters and memory write enable
    always_comb begin
        state_n = state;
        round_n = round;
        idx_n   = idx;
        tick_n  = tick;
        timer_n = timer;
        mem_we  = 1'b0;
        exp_oh  = onehot(3'(mem[AW'(idx)]));

        case (state)
            APPEND: begin
                mem_we  = 1'b1;
                round_n = round + 1'b1;
                idx_n   = '0;
                tick_n  = '0;
                state_n = SHOW_ON;
            end
            SHOW_ON: begin
                if (tick == SHOW_L) begin
                    tick_n  = '0;
                    state_n = SHOW_OFF;
                end else if (tick != '1) begin
                    tick_n = tick + 1'b1;
                end
            end
            SHOW_OFF: begin
                if (tick == GAP_L) begin
                    tick_n = '0;
                    if (idx == round - 1'b1) begin
                        idx_n   = '0;
                        timer_n = '0;
                        state_n = WAIT_IN;
                    end else begin
                        idx_n   = idx + 1'b1;
                        state_n = SHOW_ON;
                    end
                end else if (tick != '1) begin
                    tick_n = tick + 1'b1;
                end
            end
            WAIT_IN: begin
                if (press == '0) begin
                    if (timer == TO_L) begin
                        state_n = LOSE;
                    end else if (timer != '1) begin
                        timer_n = timer + 1'b1;
                    end
                end else if (8'(press) == exp_oh) begin
                    idx_n   = idx + 1'b1;
                    state_n = RELEASE;
                end else begin
                    state_n = LOSE;
                end
            end
            RELEASE: begin
                if (btn == '0) begin
                    if (idx < round) begin
                        timer_n = '0;
                        state_n = WAIT_IN;
                    end else if (round == MAX_R) begin
                        state_n = WIN;
                    end else begin
                        state_n = APPEND;
                    end
                end
            end
            IDLE, WIN, LOSE: begin
                state_n = state;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A new game wins over every other transition
        if (start_rise) begin
            state_n = APPEND;
            round_n = '0;
        end
    end

    // Output values for the state being entered, with write-through for the first element
    always_comb begin
        show_elem = (mem_we && idx_n == round) ? new_elem : mem[AW'(idx_n)];
        case (state_n)
            SHOW_ON: led_n = N_BTN'(onehot(3'(show_elem)));
            RELEASE: led_n = btn;
            WIN:     led_n = '1;
            default: led_n = '0;
        endcase

        done   = (state_n == WIN) ? round : round - 1'b1;
        best_n = best;
        if ((state_n != state) && (state_n == WIN || state_n == LOSE) && (done > best)) begin
            best_n = done;
        end
    end

    // Sequence memory is written only when a round grows; contents survive reset
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[AW'(round)] <= new_elem;
        end
    end

    // State, counters, edge-detect history and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            round   <= '0;
            best    <= '0;
            idx     <= '0;
            tick    <= '0;
            timer   <= '0;
            btn_q   <= '0;
            start_q <= 1'b0;
            led     <= '0;
            win     <= 1'b0;
            lose    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            round   <= round_n;
            best    <= best_n;
            idx     <= idx_n;
            tick    <= tick_n;
            timer   <= timer_n;
            btn_q   <= btn;
            start_q <= start;
            led     <= led_n;
            win     <= (state_n == WIN);
            lose    <= (state_n == LOSE);
            busy    <= !(state_n == IDLE || state_n == WIN || state_n == LOSE);
        end
    end

endmodule

// File: tb/tb_genius_engine.sv
// tb_genius_engine: self-checking bench for genius_engine (default build plus a MAX_LEN=4 build on shared inputs).
// Latency: outputs sampled on the falling edge, inputs driven right after sampling.
// Backpressure: n/a.
module tb_genius_engine;

    localparam int         N    = 4;
    localparam int         SHOW = 4;
    localparam int         GAP  = 2;
    localparam logic [7:0] SEED = 8'hA5;

    localparam int K_OK     = 0;
    localparam int K_WRONG  = 1;
    localparam int K_DOUBLE = 2;
    localparam int K_NONE   = 3;
    localparam int K_HELD   = 4;

    typedef struct {
        int   kind;
        int   wait_cyc;
        logic exp_lose;
        logic exp_busy;
    } vec_t;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         start;
    logic [N-1:0] btn;
    logic [N-1:0] led, led4;
    logic [4:0]   round, best;
    logic [2:0]   round4, best4;
    logic         win, lose, busy;
    logic         win4, lose4, busy4;

    int           total = 0;
    int           bad   = 0;
    logic [7:0]   ref_lfsr;
    int           seq [$];
    vec_t         tbl [8];

    genius_engine dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .btn     (btn),
        .led     (led),
        .round   (round),
        .best    (best),
        .win     (win),
        .lose    (lose),
        .busy    (busy)
    );

    genius_engine #(
        .MAX_LEN (4)
    ) dut4 (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .btn     (btn),
        .led     (led4),
        .round   (round4),
        .best    (best4),
        .win     (win4),
        .lose    (lose4),
        .busy    (busy4)
    );

    always #5 clock = ~clock;

    // Reference LFSR: feedback is the XOR of the stages named by the polynomial exponents
    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        int   taps [4];
        logic fb;
        taps = '{8, 6, 5, 4};
        fb   = 1'b0;
        foreach (taps[t]) fb ^= q[taps[t] - 1];
        return {q[6:0], fb};
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) ref_lfsr <= SEED;
        else          ref_lfsr <= lfsr_step(ref_lfsr);
    end

    function automatic int elem_of(input logic [7:0] q);
        int v;
        v = int'(q) % (1 << $clog2(N));
        if (v >= N) v -= N;
        return v;
    endfunction

    function automatic logic [N-1:0] oh(input int v);
        return N'(1 << v);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Start edge from any state; returns in the APPEND cycle with the first element recorded
    task automatic start_game();
        btn   = '0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        seq.delete();
        chk("start_busy", busy, 1);
        chk("start_round", round, 0);
        chk("start_lose", lose, 0);
        seq.push_back(elem_of(ref_lfsr));
    endtask

    // Every playback cycle: SHOW cycles lit with the element, GAP cycles dark
    task automatic playback(input logic [N-1:0] hold);
        int L;
        L = seq.size();
        for (int i = 0; i < L; i++) begin
            for (int s = 0; s < SHOW; s++) begin
                @(negedge clock);
                chk("show_led", led, oh(seq[i]));
            end
            for (int g = 0; g < GAP; g++) begin
                @(negedge clock);
                chk("gap_led", led, 0);
                if (i == L - 1 && g == GAP - 1) btn = hold;
            end
        end
        chk("show_round", round, L);
        chk("show_busy", busy, 1);
    endtask

    // Correct replay of the whole sequence with random hold times
    task automatic replay();
        int extra;
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clock);
            chk("wait_led", led, 0);
            btn = oh(seq[i]);
            @(negedge clock);
            chk("echo_led", led, oh(seq[i]));
            chk("echo_lose", lose, 0);
            extra = $urandom_range(0, 2);
            repeat (extra) begin
                @(negedge clock);
                chk("echo_hold", led, oh(seq[i]));
            end
            btn = '0;
        end
    endtask

    task automatic next_round();
        @(negedge clock);
        chk("append_led", led, 0);
        chk("append_busy", busy, 1);
        seq.push_back(elem_of(ref_lfsr));
        playback('0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: no summary after %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] right, wrong, exp_led;
        int           c;

        tbl[0] = '{K_OK,     1,  1'b0, 1'b1};
        tbl[1] = '{K_WRONG,  1,  1'b1, 1'b0};
        tbl[2] = '{K_DOUBLE, 1,  1'b1, 1'b0};
        tbl[3] = '{K_NONE,   10, 1'b0, 1'b1};
        tbl[4] = '{K_HELD,   10, 1'b0, 1'b1};
        tbl[5] = '{K_NONE,   63, 1'b0, 1'b1};
        tbl[6] = '{K_NONE,   64, 1'b1, 1'b0};
        tbl[7] = '{K_HELD,   64, 1'b1, 1'b0};

        reset_n = 1'b0;
        start   = 1'b0;
        btn     = '0;
        repeat (3) @(negedge clock);
        chk("rst_led", led, 0);
        chk("rst_round", round, 0);
        chk("rst_best", best, 0);
        chk("rst_win", win, 0);
        chk("rst_lose", lose, 0);
        chk("rst_busy", busy, 0);
        chk("rst4_led", led4, 0);
        chk("rst4_busy", busy4, 0);
        reset_n = 1'b1;

        // Round-1 playback shape
        start_game();
        playback('0);

        // Reset in the middle of SHOW_ON takes effect without a clock edge
        start_game();
        @(negedge clock);
        chk("pre_reset_led", led, oh(seq[0]));
        reset_n = 1'b0;
        #1;
        chk("mid_rst_led", led, 0);
        chk("mid_rst_round", round, 0);
        chk("mid_rst_best", best, 0);
        chk("mid_rst_win", win, 0);
        chk("mid_rst_lose", lose, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Round-1 input patterns, including the exact timeout boundary
        for (int k = 0; k < 8; k++) begin
            start_game();
            playback(tbl[k].kind == K_HELD ? oh(seq[0]) : '0);
            @(negedge clock);
            right = oh(seq[0]);
            wrong = oh((seq[0] + 1 + $urandom_range(0, N - 2)) % N);
            case (tbl[k].kind)
                K_OK:     btn = right;
                K_WRONG:  btn = wrong;
                K_DOUBLE: btn = right | wrong;
                K_HELD:   btn = right;
                default:  btn = '0;
            endcase
            repeat (tbl[k].wait_cyc) @(negedge clock);
            exp_led = (tbl[k].kind == K_OK) ? right : '0;
            chk($sformatf("tbl%0d_lose", k), lose, tbl[k].exp_lose);
            chk($sformatf("tbl%0d_busy", k), busy, tbl[k].exp_busy);
            chk($sformatf("tbl%0d_led", k), led, exp_led);
            chk($sformatf("tbl%0d_best", k), best, 0);
        end

        // Wrong button on the second element of round 2
        start_game();
        playback('0);
        replay();
        next_round();
        @(negedge clock);
        btn = oh(seq[0]);
        @(negedge clock);
        btn = '0;
        @(negedge clock);
        btn = oh((seq[1] + 1 + $urandom_range(0, N - 2)) % N);
        @(negedge clock);
        chk("r2wrong_lose", lose, 1);
        chk("r2wrong_best", best, 1);
        chk("r2wrong_busy", busy, 0);
        chk("r2wrong_led", led, 0);
        btn = '0;

        // Four perfect rounds: the MAX_LEN=4 build wins, the default build keeps going
        start_game();
        playback('0);
        for (int r = 1; r <= 4; r++) begin
            replay();
            if (r < 4) begin
                next_round();
                if (r + 1 == 3) chk("three_rounds", round, 3);
            end
        end
        @(negedge clock);
        chk("win4_win", win4, 1);
        chk("win4_led", led4, 4'hF);
        chk("win4_best", best4, 4);
        chk("win4_busy", busy4, 0);
        chk("win4_lose", lose4, 0);
        chk("win4_round", round4, 4);
        chk("main_not_win", win, 0);
        chk("main_busy", busy, 1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("restart4_win", win4, 0);
        chk("restart4_busy", busy4, 1);
        @(negedge clock);
        chk("restart4_round", round4, 1);
        chk("restart4_best", best4, 4);
        chk("aborted_best", best, 1);

        // Timeout in round 3, started while a playback is running
        start_game();
        playback('0);
        replay();
        next_round();
        replay();
        next_round();
        @(negedge clock);
        c = 0;
        while (lose !== 1'b1 && c < 200) begin
            c++;
            @(negedge clock);
        end
        chk("timeout_cycles", c, 64);
        chk("timeout_best", best, 2);
        chk("timeout_busy", busy, 0);
        chk("timeout_led", led, 0);
        chk("timeout4_lose", lose4, 1);
        chk("timeout4_best", best4, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
